// File: rtl/alu_rs_if.sv
// Issue, CDB and dispatch buses of the ALU reservation station.
// The slave side is the station; the master side is the issue stage and the CDB sources.
interface alu_rs_if #(
    parameter int ROB_SZ_LOG = 4
);
    logic                  issue_flg;
    logic [ROB_SZ_LOG:0]   issue_rd;
    logic [31:0]           issue_Vj;
    logic [31:0]           issue_Vk;
    logic [ROB_SZ_LOG:0]   issue_Qj;
    logic [ROB_SZ_LOG:0]   issue_Qk;
    logic                  issue_Qj_flg;
    logic                  issue_Qk_flg;
    logic [31:0]           issue_imm;
    logic [31:0]           issue_pc;
    logic [3:0]            issue_opcode;
    logic [3:0]            issue_optype;

    logic                  cdb_alu_flg;
    logic [ROB_SZ_LOG:0]   cdb_alu_rd;
    logic [31:0]           cdb_alu_res;
    logic                  cdb_lsb_flg;
    logic [ROB_SZ_LOG:0]   cdb_lsb_rd;
    logic [31:0]           cdb_lsb_res;

    logic                  full;
    logic                  run_flg;
    logic [ROB_SZ_LOG:0]   rd_to;
    logic [31:0]           Vj;
    logic [31:0]           Vk;
    logic [31:0]           imm;
    logic [31:0]           pc;
    logic [3:0]            opcode;
    logic [3:0]            optype;

    modport slave (
        input  issue_flg, issue_rd, issue_Vj, issue_Vk, issue_Qj, issue_Qk,
               issue_Qj_flg, issue_Qk_flg, issue_imm, issue_pc, issue_opcode, issue_optype,
               cdb_alu_flg, cdb_alu_rd, cdb_alu_res, cdb_lsb_flg, cdb_lsb_rd, cdb_lsb_res,
        output full, run_flg, rd_to, Vj, Vk, imm, pc, opcode, optype
    );

    modport master (
        output issue_flg, issue_rd, issue_Vj, issue_Vk, issue_Qj, issue_Qk,
               issue_Qj_flg, issue_Qk_flg, issue_imm, issue_pc, issue_opcode, issue_optype,
               cdb_alu_flg, cdb_alu_rd, cdb_alu_res, cdb_lsb_flg, cdb_lsb_rd, cdb_lsb_res,
        input  full, run_flg, rd_to, Vj, Vk, imm, pc, opcode, optype
    );
endinterface

// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU: buffers ops, snoops the CDBs,
// and issues the lowest-index ready entry as a registered one-cycle strobe.
module alu_rs #(
    parameter int RS_SZ_LOG  = 4,
    parameter int ROB_SZ_LOG = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      clr,
    alu_rs_if.slave   bus
);
    localparam int RS_N = 1 << RS_SZ_LOG;

    typedef logic [ROB_SZ_LOG:0] tag_t;

    typedef struct packed {
        logic        valid;
        logic        qj_flg;
        logic        qk_flg;
        tag_t        rd;
        tag_t        qj;
        tag_t        qk;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  opcode;
        logic [3:0]  optype;
    } entry_t;

    entry_t                ent     [RS_N];
    entry_t                ent_nxt [RS_N];
    entry_t                new_ent;
    logic [RS_SZ_LOG-1:0]  disp_idx;
    logic [RS_SZ_LOG-1:0]  free_idx;
    logic                  disp_found;
    logic                  free_found;
    logic                  full_q;
    logic                  full_nxt;
    logic                  run_flg_q;
    tag_t                  rd_to_q;
    logic [31:0]           vj_q;
    logic [31:0]           vk_q;
    logic [31:0]           imm_q;
    logic [31:0]           pc_q;
    logic [3:0]            opcode_q;
    logic [3:0]            optype_q;

    function automatic logic hit(input logic flg, input tag_t bus_tag, input tag_t want);
        return flg && (bus_tag == want);
    endfunction

    // Incoming op, with operands already captured if their producer is on a CDB this cycle.
    always_comb begin
        new_ent        = '0;
        new_ent.valid  = 1'b1;
        new_ent.rd     = bus.issue_rd;
        new_ent.qj     = bus.issue_Qj;
        new_ent.qk     = bus.issue_Qk;
        new_ent.qj_flg = bus.issue_Qj_flg;
        new_ent.qk_flg = bus.issue_Qk_flg;
        new_ent.vj     = bus.issue_Vj;
        new_ent.vk     = bus.issue_Vk;
        new_ent.imm    = bus.issue_imm;
        new_ent.pc     = bus.issue_pc;
        new_ent.opcode = bus.issue_opcode;
        new_ent.optype = bus.issue_optype;
        if (bus.issue_Qj_flg) begin
            if (hit(bus.cdb_alu_flg, bus.cdb_alu_rd, bus.issue_Qj)) begin
                new_ent.vj     = bus.cdb_alu_res;
                new_ent.qj_flg = 1'b0;
            end else if (hit(bus.cdb_lsb_flg, bus.cdb_lsb_rd, bus.issue_Qj)) begin
                new_ent.vj     = bus.cdb_lsb_res;
                new_ent.qj_flg = 1'b0;
            end
        end
        if (bus.issue_Qk_flg) begin
            if (hit(bus.cdb_alu_flg, bus.cdb_alu_rd, bus.issue_Qk)) begin
                new_ent.vk     = bus.cdb_alu_res;
                new_ent.qk_flg = 1'b0;
            end else if (hit(bus.cdb_lsb_flg, bus.cdb_lsb_rd, bus.issue_Qk)) begin
                new_ent.vk     = bus.cdb_lsb_res;
                new_ent.qk_flg = 1'b0;
            end
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_N - 1; i >= 0; i--) begin
            if (ent[i].valid && !ent[i].qj_flg && !ent[i].qk_flg) begin
                disp_found = 1'b1;
                disp_idx   = RS_SZ_LOG'(i);
            end
            if (!ent[i].valid) begin
                free_found = 1'b1;
                free_idx   = RS_SZ_LOG'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_N; i++) begin
            ent_nxt[i] = ent[i];
            if (ent[i].valid && ent[i].qj_flg) begin
                if (hit(bus.cdb_alu_flg, bus.cdb_alu_rd, ent[i].qj)) begin
                    ent_nxt[i].vj     = bus.cdb_alu_res;
                    ent_nxt[i].qj_flg = 1'b0;
                end else if (hit(bus.cdb_lsb_flg, bus.cdb_lsb_rd, ent[i].qj)) begin
                    ent_nxt[i].vj     = bus.cdb_lsb_res;
                    ent_nxt[i].qj_flg = 1'b0;
                end
            end
            if (ent[i].valid && ent[i].qk_flg) begin
                if (hit(bus.cdb_alu_flg, bus.cdb_alu_rd, ent[i].qk)) begin
                    ent_nxt[i].vk     = bus.cdb_alu_res;
                    ent_nxt[i].qk_flg = 1'b0;
                end else if (hit(bus.cdb_lsb_flg, bus.cdb_lsb_rd, ent[i].qk)) begin
                    ent_nxt[i].vk     = bus.cdb_lsb_res;
                    ent_nxt[i].qk_flg = 1'b0;
                end
            end
        end
        if (disp_found) begin
            ent_nxt[disp_idx].valid = 1'b0;
        end
        if (bus.issue_flg && !full_q && free_found) begin
            ent_nxt[free_idx] = new_ent;
        end
        full_nxt = 1'b1;
        for (int i = 0; i < RS_N; i++) begin
            full_nxt = full_nxt & ent_nxt[i].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_N; i++) begin
                ent[i].valid <= 1'b0;
            end
            full_q    <= 1'b0;
            run_flg_q <= 1'b0;
            rd_to_q   <= '0;
            vj_q      <= '0;
            vk_q      <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            opcode_q  <= '0;
            optype_q  <= '0;
        end else if (rdy) begin
            if (clr) begin
                for (int i = 0; i < RS_N; i++) begin
                    ent[i].valid <= 1'b0;
                end
                full_q    <= 1'b0;
                run_flg_q <= 1'b0;
            end else begin
                for (int i = 0; i < RS_N; i++) begin
                    ent[i] <= ent_nxt[i];
                end
                full_q    <= full_nxt;
                run_flg_q <= disp_found;
                if (disp_found) begin
                    rd_to_q  <= ent[disp_idx].rd;
                    vj_q     <= ent[disp_idx].vj;
                    vk_q     <= ent[disp_idx].vk;
                    imm_q    <= ent[disp_idx].imm;
                    pc_q     <= ent[disp_idx].pc;
                    opcode_q <= ent[disp_idx].opcode;
                    optype_q <= ent[disp_idx].optype;
                end
            end
        end
    end

    assign bus.full    = full_q;
    assign bus.run_flg = run_flg_q;
    assign bus.rd_to   = rd_to_q;
    assign bus.Vj      = vj_q;
    assign bus.Vk      = vk_q;
    assign bus.imm     = imm_q;
    assign bus.pc      = pc_q;
    assign bus.opcode  = opcode_q;
    assign bus.optype  = optype_q;
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: vector table plus hand sequences for wakeup, full, freeze and flush;
// every dispatch is checked against a queue of expected ops filled at issue time.
module tb_alu_rs;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clr;

    always #5 clk = ~clk;

    alu_rs_if #(.ROB_SZ_LOG(4)) b();

    alu_rs #(.RS_SZ_LOG(4), .ROB_SZ_LOG(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (b)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  opc;
        logic [3:0]  opt;
    } exp_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  opc;
        logic [3:0]  opt;
        logic        qjf;
        logic [4:0]  qj;
        logic        qkf;
        logic [4:0]  qk;
        logic        af;
        logic [4:0]  ard;
        logic [31:0] ares;
        logic        lf;
        logic [4:0]  lrd;
        logic [31:0] lres;
        logic [31:0] exp_vj;
        logic [31:0] exp_vk;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic rdy_q  = 1'b0;

    always @(posedge clk) rdy_q <= rdy;

    // Scoreboard: a dispatch only counts when the edge that produced it had rdy=1.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (rdy_q && b.run_flg) begin
            got = {b.rd_to, b.Vj, b.Vk, b.imm, b.pc, b.opcode, b.optype};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL dispatch_unexpected: actual rd_to=%0d Vj=%h Vk=%h, required no dispatch",
                         b.rd_to, b.Vj, b.Vk);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL dispatch: actual %h required %h", got, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        b.issue_flg    = 1'b0;
        b.issue_rd     = '0;
        b.issue_Vj     = '0;
        b.issue_Vk     = '0;
        b.issue_Qj     = '0;
        b.issue_Qk     = '0;
        b.issue_Qj_flg = 1'b0;
        b.issue_Qk_flg = 1'b0;
        b.issue_imm    = '0;
        b.issue_pc     = '0;
        b.issue_opcode = '0;
        b.issue_optype = '0;
        b.cdb_alu_flg  = 1'b0;
        b.cdb_alu_rd   = '0;
        b.cdb_alu_res  = '0;
        b.cdb_lsb_flg  = 1'b0;
        b.cdb_lsb_rd   = '0;
        b.cdb_lsb_res  = '0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic [31:0] vj, input logic [31:0] vk,
                             input logic [31:0] imm, input logic [31:0] pc,
                             input logic [3:0] opc, input logic [3:0] opt,
                             input logic qjf, input logic [4:0] qj,
                             input logic qkf, input logic [4:0] qk);
        b.issue_flg    = 1'b1;
        b.issue_rd     = rd;
        b.issue_Vj     = vj;
        b.issue_Vk     = vk;
        b.issue_imm    = imm;
        b.issue_pc     = pc;
        b.issue_opcode = opc;
        b.issue_optype = opt;
        b.issue_Qj_flg = qjf;
        b.issue_Qj     = qj;
        b.issue_Qk_flg = qkf;
        b.issue_Qk     = qk;
    endtask

    task automatic set_alu(input logic f, input logic [4:0] rd, input logic [31:0] res);
        b.cdb_alu_flg = f;
        b.cdb_alu_rd  = rd;
        b.cdb_alu_res = res;
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{5'd3,  32'd5,      32'd7,      32'h100, 32'h40, 4'd1, 4'd2,
                  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,
                  32'd5, 32'd7};
        vt[1] = '{5'd9,  32'h1111,   32'h2222,   32'h0,   32'h44, 4'd3, 4'd4,
                  1'b0, 5'd2,  1'b0, 5'd0,  1'b1, 5'd2,  32'd99,       1'b0, 5'd0,  32'd0,
                  32'h1111, 32'h2222};
        vt[2] = '{5'd5,  32'd1,      32'hBAD,    32'h8,   32'h48, 4'd5, 4'd6,
                  1'b0, 5'd0,  1'b1, 5'd6,  1'b0, 5'd0,  32'd0,        1'b1, 5'd6,  32'd9,
                  32'd1, 32'd9};
        vt[3] = '{5'd10, 32'hBAD,    32'hBAD,    32'hC,   32'h4C, 4'd7, 4'd8,
                  1'b1, 5'd17, 1'b1, 5'd3,  1'b1, 5'd17, 32'hDEADBEEF, 1'b1, 5'd3,  32'h1234,
                  32'hDEADBEEF, 32'h1234};
        vt[4] = '{5'd31, 32'hBAD,    32'd4,      32'hFFFF_FFFF, 32'h50, 4'd15, 4'd15,
                  1'b1, 5'd31, 1'b0, 5'd31, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0,
                  32'hFFFF_FFFF, 32'd4};
        vt[5] = '{5'd0,  32'd3,      32'hBAD,    32'h10,  32'h54, 4'd0, 4'd0,
                  1'b0, 5'd0,  1'b1, 5'd8,  1'b1, 5'd8,  32'd77,       1'b0, 5'd0,  32'd0,
                  32'd3, 32'd77};
        vt[6] = '{5'd12, 32'hBAD,    32'd6,      32'h14,  32'h58, 4'd9, 4'd10,
                  1'b1, 5'd12, 1'b0, 5'd0,  1'b0, 5'd0,  32'd0,        1'b1, 5'd12, 32'h55,
                  32'h55, 32'd6};

        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        idle_bus();
        tick();
        tick();
        chk("reset_run_flg", 32'(b.run_flg), 32'd0);
        chk("reset_full",    32'(b.full),    32'd0);
        chk("reset_rd_to",   32'(b.rd_to),   32'd0);
        chk("reset_Vj",      b.Vj,           32'd0);
        rst = 1'b0;
        tick();

        // Single ready op: one edge to enter, one edge to dispatch.
        set_issue(5'd3, 32'd5, 32'd7, 32'h100, 32'h40, 4'd1, 4'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        sb.push_back({5'd3, 32'd5, 32'd7, 32'h100, 32'h40, 4'd1, 4'd2});
        tick();
        idle_bus();
        chk("issue_not_yet", 32'(b.run_flg), 32'd0);
        tick();
        chk("fast_run_flg", 32'(b.run_flg), 32'd1);
        chk("fast_rd_to",   32'(b.rd_to),   32'd3);
        chk("fast_Vj",      b.Vj,           32'd5);
        chk("fast_Vk",      b.Vk,           32'd7);

        // rdy low freezes outputs and drops the offered issue.
        rdy = 1'b0;
        set_issue(5'd8, 32'd1, 32'd1, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("freeze_run_flg", 32'(b.run_flg), 32'd1);
        chk("freeze_rd_to",   32'(b.rd_to),   32'd3);
        rdy = 1'b1;
        idle_bus();
        tick();
        chk("after_dispatch_run_flg", 32'(b.run_flg), 32'd0);
        tick();
        chk("frozen_issue_dropped", 32'(b.run_flg), 32'd0);

        // Pending Vj woken by ALU broadcast; a tag differing only in the top bit must not wake it.
        set_issue(5'd4, 32'hBAD, 32'd11, 32'h20, 32'h80, 4'd2, 4'd3, 1'b1, 5'd2, 1'b0, 5'd0);
        sb.push_back({5'd4, 32'h10, 32'd11, 32'h20, 32'h80, 4'd2, 4'd3});
        tick();
        idle_bus();
        tick();
        chk("pending_hold", 32'(b.run_flg), 32'd0);
        set_alu(1'b1, 5'd18, 32'h77);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        tick();
        chk("tag_full_width", 32'(b.run_flg), 32'd0);
        set_alu(1'b1, 5'd2, 32'h10);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        chk("wake_latency", 32'(b.run_flg), 32'd0);
        tick();
        chk("wake_run_flg", 32'(b.run_flg), 32'd1);
        chk("wake_Vj",      b.Vj,           32'h10);
        tick();

        // Back-to-back table vectors, each with its own same-cycle CDB traffic.
        for (int i = 0; i < 7; i++) begin
            set_issue(vt[i].rd, vt[i].vj, vt[i].vk, vt[i].imm, vt[i].pc, vt[i].opc, vt[i].opt,
                      vt[i].qjf, vt[i].qj, vt[i].qkf, vt[i].qk);
            set_alu(vt[i].af, vt[i].ard, vt[i].ares);
            b.cdb_lsb_flg = vt[i].lf;
            b.cdb_lsb_rd  = vt[i].lrd;
            b.cdb_lsb_res = vt[i].lres;
            sb.push_back({vt[i].rd, vt[i].exp_vj, vt[i].exp_vk, vt[i].imm, vt[i].pc,
                          vt[i].opc, vt[i].opt});
            tick();
        end
        idle_bus();
        tick();
        tick();
        chk("table_drained", 32'(sb.size()), 32'd0);

        // Fill all 16 entries waiting on tag 1.
        for (int i = 0; i < 16; i++) begin
            set_issue(5'(16 + i), 32'hBAD, 32'(i), 32'(i * 3), 32'h1000 + 32'(i * 4),
                      4'(i), 4'(15 - i), 1'b1, 5'd1, 1'b0, 5'd0);
            sb.push_back({5'(16 + i), 32'hA5A5, 32'(i), 32'(i * 3), 32'h1000 + 32'(i * 4),
                          4'(i), 4'(15 - i)});
            tick();
            if (i == 14) chk("full_at_15", 32'(b.full), 32'd0);
        end
        idle_bus();
        chk("full_at_16", 32'(b.full), 32'd1);
        set_issue(5'd30, 32'd1, 32'd2, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle_bus();
        chk("full_issue_ignored", 32'(b.full), 32'd1);
        chk("full_no_run",        32'(b.run_flg), 32'd0);
        set_alu(1'b1, 5'd1, 32'hA5A5);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        chk("bcast_latency", 32'(b.run_flg), 32'd0);
        tick();
        chk("drain_first_run", 32'(b.run_flg), 32'd1);
        chk("drain_first_rd",  32'(b.rd_to),   32'd16);
        chk("drain_full_clr",  32'(b.full),    32'd0);
        for (int k = 1; k < 16; k++) tick();
        chk("drain_last_rd", 32'(b.rd_to), 32'd31);
        tick();
        chk("drain_done_run", 32'(b.run_flg), 32'd0);
        chk("fill_drained",   32'(sb.size()), 32'd0);

        // Flush with a ready entry about to dispatch and a same-cycle issue.
        set_issue(5'd20, 32'hBAD, 32'd1, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1, 5'd9, 1'b0, 5'd0);
        tick();
        set_issue(5'd21, 32'hBAD, 32'd1, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1, 5'd9, 1'b0, 5'd0);
        tick();
        set_issue(5'd22, 32'd1, 32'd1, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        clr = 1'b1;
        set_issue(5'd23, 32'd2, 32'd2, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        clr = 1'b0;
        idle_bus();
        chk("clr_run_flg", 32'(b.run_flg), 32'd0);
        chk("clr_full",    32'(b.full),    32'd0);
        set_alu(1'b1, 5'd9, 32'h33);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        chk("clr_no_dispatch", 32'(b.run_flg), 32'd0);
        set_issue(5'd24, 32'h24, 32'h42, 32'h7, 32'h90, 4'd6, 4'd1, 1'b0, 5'd0, 1'b0, 5'd0);
        sb.push_back({5'd24, 32'h24, 32'h42, 32'h7, 32'h90, 4'd6, 4'd1});
        tick();
        idle_bus();
        tick();
        chk("post_clr_run", 32'(b.run_flg), 32'd1);
        chk("post_clr_rd",  32'(b.rd_to),   32'd24);
        tick();
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
